// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one memory port between an instruction read port and a
//            data read/write port. Default build gives the data port priority
//            with an instruction starvation guard; define MEM_ARB_RR_EN for
//            round-robin arbitration instead.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  // instruction read port
  input  logic [AW-1:0] i_addr,
  input  logic          i_rstrb,
  output logic [31:0]   i_rdata,
  output logic          i_rbusy,
  // data port
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_wmask,
  input  logic          d_wstrb,
  input  logic          d_rstrb,
  output logic [31:0]   d_rdata,
  output logic          d_rbusy,
  output logic          d_wbusy,
  // shared memory port
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_wmask,
  output logic          m_wstrb,
  output logic          m_rstrb,
  input  logic [31:0]   m_rdata,
  input  logic          m_rbusy,
  input  logic          m_wbusy,
  // current owner
  output logic          gnt_i,
  output logic          gnt_d
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_I = 2'd1,
    ST_OWN_D = 2'd2
  } state_t;

  state_t r_state;

`ifdef MEM_ARB_RR_EN
  logic r_last_gnt_d;
`else
  localparam logic [2:0] C_STARVE_MAX = 3'(STARVE_MAX);
  logic [2:0] r_starve_cnt;
`endif

  logic w_req_i;
  logic w_req_d;
  logic w_pick_i;
  logic w_pick_d;
  logic w_own_i;
  logic w_own_d;
  logic w_d_rd;
  logic w_done_i;
  logic w_done_d;

  // ---------------------------------------------------------------------------
  // Arbitration decision, only acted upon in IDLE
  // ---------------------------------------------------------------------------
  assign w_req_i = i_rstrb;
  assign w_req_d = d_rstrb | d_wstrb;

`ifdef MEM_ARB_RR_EN
  assign w_pick_i = w_req_i & (~w_req_d | r_last_gnt_d);
`else
  assign w_pick_i = w_req_i & (~w_req_d | (r_starve_cnt == C_STARVE_MAX));
`endif
  assign w_pick_d = w_req_d & ~w_pick_i;

  // ---------------------------------------------------------------------------
  // Ownership and completion; reset masks everything in the cycle it is seen
  // ---------------------------------------------------------------------------
  assign w_own_i  = (r_state == ST_OWN_I) & ~rst;
  assign w_own_d  = (r_state == ST_OWN_D) & ~rst;

  // A data request with both strobes high is a write.
  assign w_d_rd   = d_rstrb & ~d_wstrb;

  assign w_done_i = w_own_i & i_rstrb & ~m_rbusy;
  assign w_done_d = w_own_d & ((d_wstrb & ~m_wbusy) | (w_d_rd & ~m_rbusy));

  assign gnt_i    = w_own_i;
  assign gnt_d    = w_own_d;

  assign m_rstrb  = (w_own_i & i_rstrb) | (w_own_d & w_d_rd);
  assign m_wstrb  = w_own_d & d_wstrb;

  assign i_rbusy  = i_rstrb & ~w_done_i;
  assign d_wbusy  = d_wstrb & ~w_done_d;
  assign d_rbusy  = d_rstrb & ~(w_done_d & w_d_rd);

  assign i_rdata  = w_done_i ? m_rdata : 32'd0;
  assign d_rdata  = w_done_d ? m_rdata : 32'd0;

  always_comb begin
    m_addr  = '0;
    m_wdata = 32'd0;
    m_wmask = 4'd0;
    if (w_own_i) begin
      m_addr = i_addr;
    end else if (w_own_d) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_wmask = d_wmask;
    end
  end

  // ---------------------------------------------------------------------------
  // Ownership FSM and arbitration history
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
`ifdef MEM_ARB_RR_EN
      r_last_gnt_d <= 1'b1;
`else
      r_starve_cnt <= 3'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_i) begin
            r_state <= ST_OWN_I;
`ifdef MEM_ARB_RR_EN
            r_last_gnt_d <= 1'b0;
`else
            r_starve_cnt <= 3'd0;
`endif
          end else if (w_pick_d) begin
            r_state <= ST_OWN_D;
`ifdef MEM_ARB_RR_EN
            r_last_gnt_d <= 1'b1;
`else
            // Instruction port lost a contended arbitration.
            if (w_req_i && (r_starve_cnt != C_STARVE_MAX)) begin
              r_starve_cnt <= r_starve_cnt + 3'd1;
            end
`endif
          end
        end
        // Dropping the strobe before completion aborts the transfer.
        ST_OWN_I: begin
          if (!i_rstrb || w_done_i) begin
            r_state <= ST_IDLE;
          end
        end
        ST_OWN_D: begin
          if (!w_req_d || w_done_d) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter with a transfer-level
//            reference model checked every cycle. Honours MEM_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW         = 32;
  localparam int STARVE_MAX = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] i_addr;
  logic          i_rstrb;
  logic [31:0]   i_rdata;
  logic          i_rbusy;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_wmask;
  logic          d_wstrb;
  logic          d_rstrb;
  logic [31:0]   d_rdata;
  logic          d_rbusy;
  logic          d_wbusy;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_wmask;
  logic          m_wstrb;
  logic          m_rstrb;
  logic [31:0]   m_rdata;
  logic          m_rbusy;
  logic          m_wbusy;
  logic          gnt_i;
  logic          gnt_d;

  mem_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rstrb(i_rstrb), .i_rdata(i_rdata), .i_rbusy(i_rbusy),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask), .d_wstrb(d_wstrb),
    .d_rstrb(d_rstrb), .d_rdata(d_rdata), .d_rbusy(d_rbusy), .d_wbusy(d_wbusy),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask), .m_wstrb(m_wstrb),
    .m_rstrb(m_rstrb), .m_rdata(m_rdata), .m_rbusy(m_rbusy), .m_wbusy(m_wbusy),
    .gnt_i(gnt_i), .gnt_d(gnt_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who holds the bus, how often I has lost, who went last
  // ---------------------------------------------------------------------------
  typedef enum int {NOBODY, INSTR, DATA} who_t;

  who_t owner = NOBODY;
  int   lost  = 0;
  who_t last  = DATA;

  function automatic bit owns(input who_t w);
    return !rst && (owner == w);
  endfunction

  function automatic bit i_finishing();
    return owns(INSTR) && i_rstrb && !m_rbusy;
  endfunction

  function automatic bit d_finishing();
    if (!owns(DATA)) return 1'b0;
    if (d_wstrb) return !m_wbusy;
    return d_rstrb && !m_rbusy;
  endfunction

  always @(posedge clk) begin : model_step
    who_t win;
    if (rst) begin
      owner = NOBODY;
      lost  = 0;
      last  = DATA;
    end else if (owner == NOBODY) begin
      if (i_rstrb && (d_rstrb || d_wstrb)) begin
`ifdef MEM_ARB_RR_EN
        win = (last == DATA) ? INSTR : DATA;
`else
        win = (lost == STARVE_MAX) ? INSTR : DATA;
        if (win == DATA && lost < STARVE_MAX) lost = lost + 1;
`endif
      end else if (i_rstrb) begin
        win = INSTR;
      end else if (d_rstrb || d_wstrb) begin
        win = DATA;
      end else begin
        win = NOBODY;
      end
      if (win == INSTR) lost = 0;
      if (win != NOBODY) last = win;
      owner = win;
    end else if (owner == INSTR) begin
      if (!i_rstrb || i_finishing()) owner = NOBODY;
    end else begin
      if (!(d_rstrb || d_wstrb) || d_finishing()) owner = NOBODY;
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] e_addr;
    e_addr = owns(INSTR) ? i_addr : (owns(DATA) ? d_addr : 32'd0);
    chk("gnt_i",   32'(gnt_i),   32'(owns(INSTR)));
    chk("gnt_d",   32'(gnt_d),   32'(owns(DATA)));
    chk("m_addr",  m_addr,       e_addr);
    chk("m_wdata", m_wdata,      owns(DATA) ? d_wdata : 32'd0);
    chk("m_wmask", 32'(m_wmask), owns(DATA) ? 32'(d_wmask) : 32'd0);
    chk("m_rstrb", 32'(m_rstrb), 32'((owns(INSTR) && i_rstrb) || (owns(DATA) && d_rstrb && !d_wstrb)));
    chk("m_wstrb", 32'(m_wstrb), 32'(owns(DATA) && d_wstrb));
    chk("i_rbusy", 32'(i_rbusy), 32'(i_rstrb && !i_finishing()));
    chk("d_wbusy", 32'(d_wbusy), 32'(d_wstrb && !d_finishing()));
    chk("d_rbusy", 32'(d_rbusy), 32'(d_rstrb && !(d_finishing() && !d_wstrb)));
    chk("i_rdata", i_rdata,      i_finishing() ? m_rdata : 32'd0);
    chk("d_rdata", d_rdata,      d_finishing() ? m_rdata : 32'd0);
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  string order;
  string exp_order;

  initial begin
    rst = 1'b1;
    i_addr = '0; i_rstrb = 1'b0;
    d_addr = '0; d_wdata = 32'd0; d_wmask = 4'd0; d_wstrb = 1'b0; d_rstrb = 1'b0;
    m_rdata = 32'd0; m_rbusy = 1'b0; m_wbusy = 1'b0;
    order = "";
`ifdef MEM_ARB_RR_EN
    exp_order = "IDIDID";
`else
    exp_order = "DDDDID";
`endif

    // Reset: nothing granted, busy mirrors strobe.
    step();
    i_rstrb = 1'b1; d_wstrb = 1'b1;
    @(negedge clk);
    chk("rst_gnt_i",   32'(gnt_i),   32'd0);
    chk("rst_m_rstrb", 32'(m_rstrb), 32'd0);
    chk("rst_m_wstrb", 32'(m_wstrb), 32'd0);
    chk("rst_i_rbusy", 32'(i_rbusy), 32'd1);
    chk("rst_d_wbusy", 32'(d_wbusy), 32'd1);
    step();
    rst = 1'b0; i_rstrb = 1'b0; d_wstrb = 1'b0;

    // Zero-wait instruction read.
    step();
    i_rstrb = 1'b1; i_addr = 32'h100; m_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("ird_c0_m_rstrb", 32'(m_rstrb), 32'd0);
    chk("ird_c0_i_rbusy", 32'(i_rbusy), 32'd1);
    step();
    @(negedge clk);
    chk("ird_c1_m_rstrb", 32'(m_rstrb), 32'd1);
    chk("ird_c1_m_addr",  m_addr,       32'h100);
    chk("ird_c1_i_rbusy", 32'(i_rbusy), 32'd0);
    chk("ird_c1_i_rdata", i_rdata,      32'hDEADBEEF);
    step();
    i_rstrb = 1'b0;
    @(negedge clk);
    chk("ird_c2_gnt_i", 32'(gnt_i), 32'd0);

    // Data write with three memory wait cycles.
    step();
    d_wstrb = 1'b1; d_addr = 32'h204; d_wmask = 4'b0100; d_wdata = 32'hCAFEF00D; m_wbusy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wr_busy_d_wbusy", 32'(d_wbusy), 32'd1);
      if (k > 0) chk("wr_m_wmask", 32'(m_wmask), 32'h4);
      step();
    end
    m_wbusy = 1'b0;
    @(negedge clk);
    chk("wr_c4_d_wbusy", 32'(d_wbusy), 32'd0);
    chk("wr_c4_m_wstrb", 32'(m_wstrb), 32'd1);
    chk("wr_c4_m_addr",  m_addr,       32'h204);
    step();
    d_wstrb = 1'b0;

    // Continuous contention from both ports after a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0; i_rstrb = 1'b1; d_rstrb = 1'b1; i_addr = 32'h80; d_addr = 32'h90;
    m_rdata = 32'h0BADC0DE;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (gnt_i) order = {order, "I"};
      else if (gnt_d) order = {order, "D"};
      step();
    end
    i_rstrb = 1'b0; d_rstrb = 1'b0;
    chk("grant_count", 32'(order.len()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("grant_order[%0d]", k), 32'(order[k]), 32'(exp_order[k]));
    end

    // Data read aborted while the memory is busy; pending I follows.
    step();
    d_rstrb = 1'b1; d_addr = 32'h300; m_rbusy = 1'b1;
    step();
    i_rstrb = 1'b1; i_addr = 32'h180;
    @(negedge clk);
    chk("abt_c1_gnt_d",   32'(gnt_d),   32'd1);
    chk("abt_c1_m_rstrb", 32'(m_rstrb), 32'd1);
    chk("abt_c1_d_rbusy", 32'(d_rbusy), 32'd1);
    step();
    d_rstrb = 1'b0;
    @(negedge clk);
    chk("abt_c2_m_rstrb", 32'(m_rstrb), 32'd0);
    chk("abt_c2_d_rdata", d_rdata,      32'd0);
    chk("abt_c2_i_rbusy", 32'(i_rbusy), 32'd1);
    step();
    @(negedge clk);
    chk("abt_c3_gnt_d", 32'(gnt_d), 32'd0);
    chk("abt_c3_gnt_i", 32'(gnt_i), 32'd0);
    step();
    @(negedge clk);
    chk("abt_c4_gnt_i",  32'(gnt_i), 32'd1);
    chk("abt_c4_m_addr", m_addr,      32'h180);

    // Reset pulse while I owns the bus with a stalled memory.
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rstp_during_m_rstrb", 32'(m_rstrb), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstp_gnt_i",   32'(gnt_i),   32'd0);
    chk("rstp_m_rstrb", 32'(m_rstrb), 32'd0);
    chk("rstp_i_rbusy", 32'(i_rbusy), 32'd1);
    m_rbusy = 1'b0;
    step();
    m_rdata = 32'h12345678;
    @(negedge clk);
    chk("rstp_regrant_i_rdata", i_rdata,      32'h12345678);
    chk("rstp_regrant_i_rbusy", 32'(i_rbusy), 32'd0);
    step();
    i_rstrb = 1'b0;

    // Both data strobes high behaves as a write.
    step();
    d_wstrb = 1'b1; d_rstrb = 1'b1; d_addr = 32'h40; d_wmask = 4'hF;
    d_wdata = 32'hA5A55A5A; m_wbusy = 1'b1;
    step();
    @(negedge clk);
    chk("rw_c1_m_wstrb", 32'(m_wstrb), 32'd1);
    chk("rw_c1_m_rstrb", 32'(m_rstrb), 32'd0);
    chk("rw_c1_m_wdata", m_wdata,      32'hA5A55A5A);
    chk("rw_c1_d_rbusy", 32'(d_rbusy), 32'd1);
    step();
    m_wbusy = 1'b0;
    @(negedge clk);
    chk("rw_c2_d_wbusy", 32'(d_wbusy), 32'd0);
    chk("rw_c2_d_rbusy", 32'(d_rbusy), 32'd1);
    step();
    d_wstrb = 1'b0; d_rstrb = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: address width of all address ports.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive lost arbitrations after which the instruction port wins (fixed-priority mode only).
REQ-003 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports i_addr in AW; i_rstrb in 1; i_rdata out 32; i_rbusy out 1. These form the instruction read port.
REQ-006 SHALL have ports d_addr in AW; d_wdata in 32; d_wmask in 4; d_wstrb in 1; d_rstrb in 1; d_rdata out 32; d_rbusy out 1; d_wbusy out 1. These form the data port.
REQ-007 SHALL have ports m_addr out AW; m_wdata out 32; m_wmask out 4; m_wstrb out 1; m_rstrb out 1; m_rdata in 32; m_rbusy in 1; m_wbusy in 1. These form the shared memory port.
REQ-008 SHALL have ports gnt_i out 1 and gnt_d out 1: current owner, one-hot or zero.

Function
REQ-009 SHALL implement the bus protocol as follows on every port: requester holds strobe and address stable while busy=1; transfer completes in the cycle where strobe=1 and busy=0; read data is valid only in that cycle.
REQ-010 SHALL have FSM states IDLE, OWN_I and OWN_D; gnt_i=(state==OWN_I); gnt_d=(state==OWN_D).
REQ-011 SHALL, in IDLE, register a request (i_rstrb, or d_rstrb|d_wstrb) and move to the owner state next cycle; the downstream strobes stay 0 in IDLE.
REQ-012 SHALL, in OWN_x, drive m_addr, m_wdata and m_wmask from the owner; m_rstrb and m_wstrb are the owner's strobes, passed combinationally.
REQ-013 SHALL declare completion when in OWN_x with the owner's strobe=1 and the matching m_*busy=0; the owner's busy is 0 that cycle, d_rdata/i_rdata=m_rdata, and the next state is IDLE.
REQ-014 SHALL hold a requester's busy at 1 whenever its strobe=1 and its transfer is not completing, including while the other port owns the bus.
REQ-015 SHALL treat an owner dropping its strobe in OWN_x as an abort: downstream strobes drop the same cycle, the next state is IDLE, and no completion is reported.
REQ-016 SHALL treat d_wstrb and d_rstrb both high as a write: m_rstrb=0, d_rbusy=d_rstrb.
REQ-017 SHALL give a minimum latency of 2 cycles from strobe to completion with zero-wait memory; back-to-back accesses from one port take 2 cycles each, because IDLE is entered between grants.
REQ-018 SHALL drive i_rdata and d_rdata to 0 when the port is not completing.
REQ-019 SHALL resolve contention (both request in IDLE) according to REQ-023/REQ-024.
REQ-020 SHALL keep the 3-bit starvation counter starve_cnt as follows: it increments when i_rstrb loses an IDLE contention; it clears on an I grant; it saturates at STARVE_MAX.

Reset
REQ-021 SHALL, while rst=1, force state to IDLE, starve_cnt to 0 and last_gnt to D; all strobes, gnt_i, gnt_d and rdata outputs are 0, and busy outputs equal their strobes.
REQ-022 SHALL let rst asserted mid-transaction abandon it; the downstream strobe is 0 in the cycle after the reset edge.

Configuration
REQ-023 SHALL, with macro MEM_ARB_RR_EN defined, use round-robin arbitration: on contention the port not equal to last_gnt wins; last_gnt updates on every grant; starve_cnt is held at 0.
REQ-024 SHALL, with MEM_ARB_RR_EN undefined, give the data port fixed priority, except that the instruction port wins when starve_cnt==STARVE_MAX.

Verification
REQ-025 SHALL cover: i_rstrb=1, i_addr=0x100, zero-wait memory, m_rdata=0xDEADBEEF -> m_rstrb=1 in cycle 1, i_rbusy=0 with i_rdata=0xDEADBEEF in cycle 1, gnt_i=0 in cycle 2.
REQ-026 SHALL cover: d_wstrb=1, d_addr=0x204, d_wmask=0b0100, m_wbusy=1 for 3 cycles -> d_wbusy=1 for 4 cycles, m_wmask=0b0100, completion in cycle 4.
REQ-027 SHALL cover: i_rstrb and d_rstrb raised together and held continuously, MEM_ARB_RR_EN undefined, STARVE_MAX=4 -> grant order D,D,D,D,I,D...
REQ-028 SHALL cover: same stimulus as REQ-027 with MEM_ARB_RR_EN defined -> grant order I,D,I,D (last_gnt=D after reset).
REQ-029 SHALL cover: d_rstrb dropped while OWN_D with m_rbusy=1 -> m_rstrb=0 the same cycle, IDLE next cycle, a pending I request is granted the following cycle.
REQ-030 SHALL cover: rst pulsed in OWN_I with m_rbusy=1 -> state IDLE, m_rstrb=0, gnt_i=0 after the edge, i_rbusy=i_rstrb.
